line_scale_scheduler: RTL and testbench

//   Sequences the GBA line buffer / line cache against the HDMI output raster.

---
 rtl/line_scale_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_line_scale_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scale_scheduler.sv
// ---------------------------------------------------------------------------
// line_scale_scheduler
//
// Places a 240x160 GBA picture, scaled up by SCALE, inside the HDMI output
// raster. It tells the line buffer when to advance to the next GBA row
// (pullLine). It tells the line cache when to reload (cacheUpdate, CACHE_DLY
// cycles after each pull). It also supplies the image generator with the GBA
// column and the sub-pixel phases.
//
// Ports
//   pxlClk       in   pixel clock
//   rst          in   synchronous reset, active-high
//   frameStart   in   1-cycle pulse at the first active line of a frame
//   lineStart    in   1-cycle pulse before the first de cycle of each line
//   de           in   output active-area data enable
//   pullLine     out  1-cycle pulse: line buffer advances one GBA row
//   cacheUpdate  out  1-cycle pulse: line cache reloads its neighbourhood
//   curPxl[7:0]  out  GBA column (0..239) of the previous de cycle
//   subX[2:0]    out  horizontal phase inside the scaled pixel
//   subY[2:0]    out  vertical phase inside the scaled row
//   gbaActive    out  previous de cycle lay inside the GBA window
// ---------------------------------------------------------------------------
module line_scale_scheduler #(
    parameter int SCALE     = 4,
    parameter int H_OFFSET  = 160,
    parameter int V_OFFSET  = 40,
    parameter int CACHE_DLY = 3
) (
    input  logic       pxlClk,
    input  logic       rst,
    input  logic       frameStart,
    input  logic       lineStart,
    input  logic       de,
    output logic       pullLine,
    output logic       cacheUpdate,
    output logic [7:0] curPxl,
    output logic [2:0] subX,
    output logic [2:0] subY,
    output logic       gbaActive
);
    typedef enum logic [1:0] {IDLE, TOP, ACT, BOT} state_t;

    localparam logic [2:0]  SUB_MAX  = 3'(SCALE - 1);
    localparam logic [10:0] V_OFF    = 11'(V_OFFSET);
    localparam logic [10:0] WIN_LO   = 11'(H_OFFSET);
    localparam logic [10:0] WIN_HI   = 11'(H_OFFSET + 240 * SCALE);
    localparam logic [10:0] X_SAT    = 11'h7FF;
    localparam logic [7:0]  LAST_ROW = 8'd159;
    localparam logic [7:0]  LAST_PXL = 8'd239;

    state_t               state_q, state_d;
    logic [10:0]          v_line_q, v_line_d;
    logic [7:0]           row_cnt_q, row_cnt_d;
    logic [2:0]           sub_y_q, sub_y_d;
    logic                 pull_line_q, pull_line_d;
    logic [CACHE_DLY-1:0] pend_q, pend_d;
    logic [10:0]          x_cnt_q, x_cnt_d;
    logic [2:0]           ph_x_q, ph_x_d;      // phase the next window pixel will get
    logic [7:0]           col_cnt_q, col_cnt_d; // column the next window pixel will get
    logic [7:0]           cur_pxl_q, cur_pxl_d;
    logic [2:0]           sub_x_q, sub_x_d;
    logic                 gba_active_q, gba_active_d;
    logic                 in_win;

    // Vertical sequencing. frameStart overrides everything, including a
    // coincident lineStart, so that line becomes vLine 0.
    always_comb begin
        state_d     = state_q;
        v_line_d    = v_line_q;
        row_cnt_d   = row_cnt_q;
        sub_y_d     = sub_y_q;
        pull_line_d = 1'b0;
        if (frameStart) begin
            v_line_d  = 11'd0;
            row_cnt_d = 8'd0;
            sub_y_d   = 3'd0;
            if (V_OFF == 11'd0) begin
                state_d     = ACT;
                pull_line_d = 1'b1;
            end else begin
                state_d = TOP;
            end
        end else begin
            case (state_q)
                TOP: begin
                    if (lineStart) begin
                        v_line_d = v_line_q + 11'd1;
                        if (v_line_q + 11'd1 == V_OFF) begin
                            state_d     = ACT;
                            pull_line_d = 1'b1;
                        end
                    end
                end
                ACT: begin
                    if (lineStart) begin
                        if (sub_y_q == SUB_MAX) begin
                            sub_y_d = 3'd0;
                            // The wrap after row 159 would start row 160:
                            // no pull, the picture is finished.
                            if (row_cnt_q == LAST_ROW) begin
                                state_d = BOT;
                            end else begin
                                row_cnt_d   = row_cnt_q + 8'd1;
                                pull_line_d = 1'b1;
                            end
                        end else begin
                            sub_y_d = sub_y_q + 3'd1;
                        end
                    end
                end
                default: begin
                    // IDLE and BOT only leave on frameStart.
                    state_d = state_q;
                end
            endcase
        end
    end

    // cacheUpdate delay line; a resync flushes every pulse still in flight.
    assign pend_d[0] = pull_line_q & ~frameStart;
    generate
        for (genvar gi = 1; gi < CACHE_DLY; gi++) begin : g_pend
            assign pend_d[gi] = pend_q[gi-1] & ~frameStart;
        end
    endgenerate

    // Horizontal: x_cnt indexes de cycles since lineStart. The window
    // outputs are produced from the counters as they stood in that cycle.
    assign in_win = (x_cnt_q >= WIN_LO) && (x_cnt_q < WIN_HI);

    always_comb begin
        x_cnt_d      = x_cnt_q;
        ph_x_d       = ph_x_q;
        col_cnt_d    = col_cnt_q;
        cur_pxl_d    = cur_pxl_q;
        sub_x_d      = sub_x_q;
        gba_active_d = 1'b0;
        if ((state_q != ACT) || frameStart || lineStart) begin
            x_cnt_d   = 11'd0;
            ph_x_d    = 3'd0;
            col_cnt_d = 8'd0;
            cur_pxl_d = 8'd0;
            sub_x_d   = 3'd0;
        end else if (de) begin
            x_cnt_d   = (x_cnt_q == X_SAT) ? x_cnt_q : x_cnt_q + 11'd1;
            cur_pxl_d = col_cnt_q;
            if (in_win) begin
                gba_active_d = 1'b1;
                sub_x_d      = ph_x_q;
                if (ph_x_q == SUB_MAX) begin
                    ph_x_d = 3'd0;
                    // Column stays on 239 after the last window pixel.
                    if (col_cnt_q != LAST_PXL) begin
                        col_cnt_d = col_cnt_q + 8'd1;
                    end
                end else begin
                    ph_x_d = ph_x_q + 3'd1;
                end
            end else begin
                sub_x_d = 3'd0;
            end
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state_q      <= IDLE;
            v_line_q     <= '0;
            row_cnt_q    <= '0;
            sub_y_q      <= '0;
            pull_line_q  <= 1'b0;
            pend_q       <= '0;
            x_cnt_q      <= '0;
            ph_x_q       <= '0;
            col_cnt_q    <= '0;
            cur_pxl_q    <= '0;
            sub_x_q      <= '0;
            gba_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_line_q     <= v_line_d;
            row_cnt_q    <= row_cnt_d;
            sub_y_q      <= sub_y_d;
            pull_line_q  <= pull_line_d;
            pend_q       <= pend_d;
            x_cnt_q      <= x_cnt_d;
            ph_x_q       <= ph_x_d;
            col_cnt_q    <= col_cnt_d;
            cur_pxl_q    <= cur_pxl_d;
            sub_x_q      <= sub_x_d;
            gba_active_q <= gba_active_d;
        end
    end

    assign pullLine    = pull_line_q;
    assign cacheUpdate = pend_q[CACHE_DLY-1];
    assign curPxl      = cur_pxl_q;
    assign subX        = sub_x_q;
    assign subY        = sub_y_q;
    assign gbaActive   = gba_active_q;

endmodule

// File: tb/tb_line_scale_scheduler.sv
// ---------------------------------------------------------------------------
// tb_line_scale_scheduler
//
// Three scheduler instances share one raster stimulus: A (SCALE 4, H 160,
// V 40), B (SCALE 6, H 240, V 60) and C (SCALE 4, H 160, V 0). Only the
// selected instance is compared against hand-derived expectations. Lines
// are kept short (few de cycles) except for the lines whose horizontal
// behaviour is examined cycle by cycle.
// ---------------------------------------------------------------------------
module tb_line_scale_scheduler;
    logic pxlClk     = 1'b0;
    logic rst        = 1'b1;
    logic frameStart = 1'b0;
    logic lineStart  = 1'b0;
    logic de         = 1'b0;

    always #5 pxlClk = ~pxlClk;

    logic       pl_a, cu_a, ga_a, pl_b, cu_b, ga_b, pl_c, cu_c, ga_c;
    logic [7:0] cp_a, cp_b, cp_c;
    logic [2:0] sx_a, sx_b, sx_c, sy_a, sy_b, sy_c;

    line_scale_scheduler u_dut_a (
        .pxlClk(pxlClk), .rst(rst), .frameStart(frameStart), .lineStart(lineStart), .de(de),
        .pullLine(pl_a), .cacheUpdate(cu_a), .curPxl(cp_a), .subX(sx_a), .subY(sy_a), .gbaActive(ga_a)
    );

    line_scale_scheduler #(.SCALE(6), .H_OFFSET(240), .V_OFFSET(60), .CACHE_DLY(3)) u_dut_b (
        .pxlClk(pxlClk), .rst(rst), .frameStart(frameStart), .lineStart(lineStart), .de(de),
        .pullLine(pl_b), .cacheUpdate(cu_b), .curPxl(cp_b), .subX(sx_b), .subY(sy_b), .gbaActive(ga_b)
    );

    line_scale_scheduler #(.SCALE(4), .H_OFFSET(160), .V_OFFSET(0), .CACHE_DLY(3)) u_dut_c (
        .pxlClk(pxlClk), .rst(rst), .frameStart(frameStart), .lineStart(lineStart), .de(de),
        .pullLine(pl_c), .cacheUpdate(cu_c), .curPxl(cp_c), .subX(sx_c), .subY(sy_c), .gbaActive(ga_c)
    );

    int sel = 0;
    logic       o_pl, o_cu, o_ga;
    logic [7:0] o_cp;
    logic [2:0] o_sx, o_sy;

    always_comb begin
        o_pl = pl_a; o_cu = cu_a; o_ga = ga_a; o_cp = cp_a; o_sx = sx_a; o_sy = sy_a;
        case (sel)
            1: begin o_pl = pl_b; o_cu = cu_b; o_ga = ga_b; o_cp = cp_b; o_sx = sx_b; o_sy = sy_b; end
            2: begin o_pl = pl_c; o_cu = cu_c; o_ga = ga_c; o_cp = cp_c; o_sx = sx_c; o_sy = sy_c; end
            default: ;
        endcase
    end

    // Configuration of the selected instance.
    int h_off = 160;
    int scl   = 4;
    int v_off = 40;
    bit armed = 1'b0;   // a frameStart has been seen since the last reset

    int vec_count = 0;
    int miscompare_count = 0;

    // Per-line event capture.
    int lc, pulls, pull_off, cus, cu_off;
    int frame_pulls, frame_cus;

    task automatic check_vec(input string tag, input int got, input int exp);
        vec_count++;
        if (got != exp) begin
            miscompare_count++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic select_dut(input int s);
        sel = s;
        case (s)
            1:       begin h_off = 240; scl = 6; v_off = 60; end
            2:       begin h_off = 160; scl = 4; v_off = 0;  end
            default: begin h_off = 160; scl = 4; v_off = 40; end
        endcase
    endtask

    task automatic step();
        @(posedge pxlClk);
        #1;
        if (o_pl) begin
            pulls++;
            if (pull_off < 0) pull_off = lc;
        end
        if (o_cu) begin
            cus++;
            if (cu_off < 0) cu_off = lc;
        end
        lc++;
    endtask

    // Expected vertical behaviour of output line l of the current frame.
    function automatic void line_exp(input int l, output bit pull, output bit act, output int suby);
        act  = armed && (l >= v_off) && (l < v_off + 160 * scl);
        pull = act && (((l - v_off) % scl) == 0);
        suby = act ? (l - v_off) % scl : 0;
    endfunction

    // Expected horizontal outputs for the de cycle with index k.
    function automatic void pix_exp(input bit act, input int k, output int ga, output int cp, output int sx);
        ga = 0; cp = 0; sx = 0;
        if (act) begin
            if (k >= h_off + 240 * scl) begin
                cp = 239;
            end else if (k >= h_off) begin
                ga = 1;
                cp = (k - h_off) / scl;
                sx = (k - h_off) % scl;
            end
        end
    endfunction

    // One output line: lineStart tick, 2 blank cycles, de_len de cycles
    // (optionally broken by a 3-cycle gap before index gap_at), 3 blanks.
    task automatic run_line(input int l, input int de_len, input bit fs, input bit fs_mid,
                            input bit hchk, input int gap_at);
        bit e_pull, e_act;
        int e_suby, ga, cp, sx, ga_cnt, exp_cu;
        line_exp(l, e_pull, e_act, e_suby);
        lc = 0; pulls = 0; cus = 0; pull_off = -1; cu_off = -1; ga_cnt = 0;
        lineStart = 1'b1; frameStart = fs; de = 1'b0;
        step();
        lineStart = 1'b0; frameStart = 1'b0;
        step();
        frameStart = fs_mid;
        step();
        frameStart = 1'b0;
        for (int i = 0; i < de_len; i++) begin
            if (i == gap_at && i > 0) begin
                de = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    step();
                    if (hchk) begin
                        pix_exp(e_act, i - 1, ga, cp, sx);
                        check_vec($sformatf("gap_ga/L%0d", l), int'(o_ga), 0);
                        check_vec($sformatf("gap_cp/L%0d", l), int'(o_cp), cp);
                        check_vec($sformatf("gap_sx/L%0d", l), int'(o_sx), sx);
                    end
                end
            end
            de = 1'b1;
            step();
            if (hchk) begin
                pix_exp(e_act, i, ga, cp, sx);
                check_vec($sformatf("ga/L%0d/x%0d", l, i), int'(o_ga), ga);
                check_vec($sformatf("cp/L%0d/x%0d", l, i), int'(o_cp), cp);
                check_vec($sformatf("sx/L%0d/x%0d", l, i), int'(o_sx), sx);
                ga_cnt += int'(o_ga);
            end
        end
        de = 1'b0;
        step(); step(); step();
        check_vec($sformatf("pull_cnt/L%0d", l), pulls, int'(e_pull));
        if (e_pull) check_vec($sformatf("pull_off/L%0d", l), pull_off, 0);
        exp_cu = fs_mid ? 0 : int'(e_pull);
        check_vec($sformatf("cu_cnt/L%0d", l), cus, exp_cu);
        if (exp_cu == 1) check_vec($sformatf("cu_off/L%0d", l), cu_off, 3);
        if (!fs_mid) check_vec($sformatf("subY/L%0d", l), int'(o_sy), e_suby);
        if (hchk && e_act) check_vec($sformatf("ga_span/L%0d", l), ga_cnt, 240 * scl);
        frame_pulls += pulls;
        frame_cus   += cus;
    endtask

    task automatic run_frame(input int n_lines, input int full_line, input int full_len, input int gap_at);
        frame_pulls = 0; frame_cus = 0; armed = 1'b1;
        for (int l = 0; l < n_lines; l++) begin
            run_line(l, (l == full_line) ? full_len : 4, l == 0, 1'b0, l == full_line,
                     (l == full_line) ? gap_at : -1);
        end
    endtask

    initial begin
        select_dut(0);
        rst = 1'b1;
        repeat (3) step();
        check_vec("rst_pull", int'(o_pl), 0);
        check_vec("rst_cu",   int'(o_cu), 0);
        check_vec("rst_cp",   int'(o_cp), 0);
        check_vec("rst_sx",   int'(o_sx), 0);
        check_vec("rst_sy",   int'(o_sy), 0);
        check_vec("rst_ga",   int'(o_ga), 0);
        $display("vec reset: outputs sampled after reset");
        rst = 1'b0;
        step();

        // 720p frame, line 41 examined pixel by pixel with a de gap.
        run_frame(720, 41, 1280, 500);
        check_vec("720p_pulls", frame_pulls, 160);
        check_vec("720p_cache", frame_cus, 160);
        run_line(720, 1300, 1'b0, 1'b0, 1'b1, -1);  // BOT: window stays closed
        $display("vec 720p: pulls=%0d cacheUpdates=%0d", frame_pulls, frame_cus);

        // 1080p frame on instance B.
        select_dut(1);
        run_frame(1080, 61, 1920, 700);
        check_vec("1080p_pulls", frame_pulls, 160);
        check_vec("1080p_cache", frame_cus, 160);
        $display("vec 1080p: pulls=%0d cacheUpdates=%0d", frame_pulls, frame_cus);

        // Resync: frameStart two cycles after the pull of line 300.
        select_dut(0);
        run_frame(300, -1, 4, -1);
        run_line(300, 6, 1'b0, 1'b1, 1'b0, -1);
        frame_pulls = 0;
        for (int l = 1; l <= 50; l++) run_line(l, (l == 10) ? 400 : 4, 1'b0, 1'b0, l == 10, -1);
        check_vec("resync_pulls", frame_pulls, 3);
        $display("vec resync: pulls after restart=%0d", frame_pulls);

        // Reset mid-line while the window is open (new-frame line 51).
        lineStart = 1'b1; step(); lineStart = 1'b0; step();
        de = 1'b1;
        repeat (200) step();
        rst = 1'b1;
        step();
        check_vec("mrst_pull", int'(o_pl), 0);
        check_vec("mrst_cu",   int'(o_cu), 0);
        check_vec("mrst_cp",   int'(o_cp), 0);
        check_vec("mrst_sx",   int'(o_sx), 0);
        check_vec("mrst_sy",   int'(o_sy), 0);
        check_vec("mrst_ga",   int'(o_ga), 0);
        rst = 1'b0;
        repeat (20) step();
        de = 1'b0;
        repeat (3) step();
        armed = 1'b0;
        frame_pulls = 0;
        for (int l = 52; l <= 120; l++) run_line(l, 4, 1'b0, 1'b0, 1'b0, -1);
        check_vec("post_rst_no_pull", frame_pulls, 0);
        run_frame(50, -1, 4, -1);
        check_vec("post_rst_pulls", frame_pulls, 3);
        $display("vec midrst: pulls in first 50 lines after frameStart=%0d", frame_pulls);

        // V_OFFSET = 0 on instance C.
        select_dut(2);
        run_frame(30, 5, 1200, 300);
        check_vec("v0_pulls", frame_pulls, 8);
        $display("vec voff0: pulls in 30 lines=%0d", frame_pulls);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
